// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Holds one instruction from EX, waits for the variable-latency data-SRAM
// response on loads, extracts and extends the loaded byte/halfword/word and
// hands a 70-bit result bus to WB. Also drives the forwarding/hazard bus to ID.
//
// Optional feature macro: MEM_LOAD_FWD_EN
//   defined   : ld_pending drops as soon as load data is available in MEM.
//   undefined : ld_pending stays high for the whole MEM residency of a load.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   // EX -> MEM
   input  logic        es_to_ms_valid,
   input  logic [73:0] es_to_ms_bus,
   output logic        ms_allowin,
   // data SRAM response
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   // MEM -> WB
   input  logic        ws_allowin,
   output logic        ms_to_ws_valid,
   output logic [69:0] ms_to_ws_bus,
   // MEM -> ID forwarding / hazard
   output logic [38:0] ms_to_ds_bus
);

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_WAIT = 2'd1,
      LD_DONE = 2'd2
   } ld_state_t;

   // latched stage state
   logic        ms_valid;
   logic [73:0] ms_bus_r;
   ld_state_t   ld_state;
   ld_state_t   ld_state_nxt;
   logic [31:0] rdata_buf;
   logic        rdata_cap;

   // decoded payload fields
   logic [31:0] ms_pc;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic        ms_res_from_mem;
   logic [2:0]  ms_ld_op;
   logic [31:0] ms_alu_result;

   // handshake and datapath
   logic        ms_ready_go;
   logic        ld_pending;
   logic [1:0]  ld_offset;
   logic [31:0] ld_src_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_extracted;
   logic [31:0] final_result;

   assign ms_pc           = ms_bus_r[73:42];
   assign ms_gr_we        = ms_bus_r[41];
   assign ms_dest         = ms_bus_r[40:36];
   assign ms_res_from_mem = ms_bus_r[35];
   assign ms_ld_op        = ms_bus_r[34:32];
   assign ms_alu_result   = ms_bus_r[31:0];

   // Stage handshake: loads are ready once data is present this cycle (WAIT
   // with data_ok) or has been parked in rdata_buf (DONE).
   assign ms_ready_go    = !ms_res_from_mem
                         | ((ld_state == LD_WAIT) & data_sram_data_ok)
                         | (ld_state == LD_DONE);
   assign ms_to_ws_valid = ms_valid & ms_ready_go;
   assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);

   // Pipeline register: valid bit and payload advance whenever MEM accepts.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
         ms_bus_r <= '0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
         ms_bus_r <= es_to_ms_bus;
      end
   end

   // Load-state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ld_state <= LD_IDLE;
      end else begin
         ld_state <= ld_state_nxt;
      end
   end

   // Response buffer: holds the load word when WB is not ready to take it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf <= '0;
      end else if (rdata_cap) begin
         rdata_buf <= data_sram_rdata;
      end
   end

   // Next-state: a handoff (ms_allowin) always restarts from the incoming
   // instruction; otherwise only WAIT reacts, to data_ok with WB stalled.
   always_comb begin
      ld_state_nxt = ld_state;
      rdata_cap    = 1'b0;
      if (ms_allowin) begin
         ld_state_nxt = (es_to_ms_valid & es_to_ms_bus[35]) ? LD_WAIT : LD_IDLE;
      end else begin
         unique case (ld_state)
            LD_WAIT: begin
               if (data_sram_data_ok) begin
                  ld_state_nxt = LD_DONE;
                  rdata_cap    = 1'b1;
               end
            end
            LD_DONE: begin
               ld_state_nxt = LD_DONE;
            end
            default: begin
               ld_state_nxt = LD_IDLE;
            end
         endcase
      end
   end

   // Load extraction: pick the byte/halfword selected by the address offset
   // from the live response (WAIT) or the parked one (DONE), then extend.
   always_comb begin
      ld_offset   = ms_alu_result[1:0];
      ld_src_word = (ld_state == LD_DONE) ? rdata_buf : data_sram_rdata;
      ld_byte     = ld_src_word[7:0];
      unique case (ld_offset)
         2'd0: ld_byte = ld_src_word[7:0];
         2'd1: ld_byte = ld_src_word[15:8];
         2'd2: ld_byte = ld_src_word[23:16];
         2'd3: ld_byte = ld_src_word[31:24];
         default: ld_byte = ld_src_word[7:0];
      endcase
      ld_half = ld_offset[1] ? ld_src_word[31:16] : ld_src_word[15:0];
      unique case (ms_ld_op)
         3'b001:  ld_extracted = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  ld_extracted = {24'd0, ld_byte};
         3'b011:  ld_extracted = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_extracted = {16'd0, ld_half};
         default: ld_extracted = ld_src_word;
      endcase
      final_result = ms_res_from_mem ? ld_extracted : ms_alu_result;
   end

   // Hazard indication towards ID.
`ifdef MEM_LOAD_FWD_EN
   assign ld_pending = ms_valid & ms_res_from_mem & !ms_ready_go;
`else
   assign ld_pending = ms_valid & ms_res_from_mem;
`endif

   assign ms_to_ws_bus = {ms_pc, ms_gr_we, ms_dest, final_result};
   assign ms_to_ds_bus = {ld_pending,
                          ms_valid & ms_gr_we,
                          ms_valid ? ms_dest : 5'd0,
                          final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Table of single-instruction vectors plus hand sequences for stall,
// back-to-back, spurious-response and reset-during-wait cases. Expected WB
// bus values go through a scoreboard queue.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        es_to_ms_valid;
   logic [73:0] es_to_ms_bus;
   logic        ms_allowin;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [38:0] ms_to_ds_bus;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [69:0] sb[$];

`ifdef MEM_LOAD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic        gr_we;
      logic [4:0]  dest;
      logic        rfm;
      logic [2:0]  ld_op;
      logic [31:0] alu;
      logic [31:0] rdata;
      int unsigned dly;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_allowin        (ms_allowin),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ms_to_ds_bus      (ms_to_ds_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic vec_t mk(input string nm, input logic [31:0] pc, input logic gr_we,
                               input logic [4:0] dest, input logic rfm, input logic [2:0] ld_op,
                               input logic [31:0] alu, input logic [31:0] rdata,
                               input int unsigned dly, input logic [31:0] exp);
      vec_t v;
      v.name = nm; v.pc = pc; v.gr_we = gr_we; v.dest = dest; v.rfm = rfm;
      v.ld_op = ld_op; v.alu = alu; v.rdata = rdata; v.dly = dly; v.exp = exp;
      return v;
   endfunction

   function automatic logic [73:0] ebus(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                                        input logic rfm, input logic [2:0] ld_op, input logic [31:0] alu);
      return {pc, gr_we, dest, rfm, ld_op, alu};
   endfunction

   // Pop the scoreboard and compare against the WB bus.
   task automatic sb_cmp(input string nm);
      logic [69:0] e;
      if (sb.size() == 0) begin
         chk({nm, ":sb_empty"}, 74'd1, 74'd0);
      end else begin
         e = sb.pop_front();
         chk({nm, ":ws_bus"}, ms_to_ws_bus, e);
      end
   endtask

   // Issue one instruction with WB always ready; data_ok arrives v.dly cycles after latch.
   task automatic run_vec(input vec_t v);
      int unsigned c;
      bit done;
      int unsigned exp_cyc;
      @(negedge clk);
      ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = ebus(v.pc, v.gr_we, v.dest, v.rfm, v.ld_op, v.alu);
      #1 chk({v.name, ":allowin"}, ms_allowin, 1'b1);
      sb.push_back({v.pc, v.gr_we, v.dest, v.exp});
      exp_cyc = v.rfm ? v.dly : 1;
      c = 0;
      done = 0;
      while (!done && c < 20) begin
         @(negedge clk);
         c++;
         es_to_ms_valid = 1'b0;
         es_to_ms_bus = '0;
         data_sram_data_ok = v.rfm && (c == v.dly);
         data_sram_rdata = data_sram_data_ok ? v.rdata : $urandom;
         #1;
         if (ms_to_ws_valid) begin
            done = 1;
            chk({v.name, ":latency"}, c, exp_cyc);
            sb_cmp(v.name);
            chk({v.name, ":ds_bus"}, ms_to_ds_bus,
                {(FWD ? 1'b0 : v.rfm), v.gr_we, v.dest, v.exp});
         end else if (v.rfm) begin
            chk({v.name, ":ld_pending"}, ms_to_ds_bus[38], 1'b1);
         end
      end
      chk({v.name, ":handoff_seen"}, done, 1'b1);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1 chk({v.name, ":bubble"}, ms_to_ws_valid, 1'b0);
   endtask

   initial begin
      vecs[0]  = mk("alu",      32'h1c000000, 1'b1, 5'd5,  1'b0, 3'b000, 32'h00001234, 32'h0,        0, 32'h00001234);
      vecs[1]  = mk("lb_off2",  32'h1c000004, 1'b1, 5'd6,  1'b1, 3'b001, 32'h00000102, 32'h00800000, 3, 32'hFFFFFF80);
      vecs[2]  = mk("lbu_off1", 32'h1c000008, 1'b1, 5'd7,  1'b1, 3'b010, 32'h00000011, 32'h0000A500, 1, 32'h000000A5);
      vecs[3]  = mk("lh_off2",  32'h1c00000c, 1'b1, 5'd8,  1'b1, 3'b011, 32'h00000022, 32'h80010000, 2, 32'hFFFF8001);
      vecs[4]  = mk("lh_off0",  32'h1c000010, 1'b1, 5'd9,  1'b1, 3'b011, 32'h00000020, 32'h00007FFF, 1, 32'h00007FFF);
      vecs[5]  = mk("lhu_off0", 32'h1c000014, 1'b1, 5'd10, 1'b1, 3'b100, 32'h00000040, 32'h1234ABCD, 4, 32'h0000ABCD);
      vecs[6]  = mk("lw_off3",  32'h1c000018, 1'b1, 5'd11, 1'b1, 3'b000, 32'h00000043, 32'hCAFEBABE, 1, 32'hCAFEBABE);
      vecs[7]  = mk("ldop111",  32'h1c00001c, 1'b1, 5'd12, 1'b1, 3'b111, 32'h00000051, 32'h13572468, 2, 32'h13572468);
      vecs[8]  = mk("lb_off3",  32'h1c000020, 1'b1, 5'd13, 1'b1, 3'b001, 32'h00000063, 32'h7F000000, 1, 32'h0000007F);
      vecs[9]  = mk("lb_off0",  32'h1c000024, 1'b0, 5'd14, 1'b1, 3'b001, 32'h00000070, 32'h000000FF, 1, 32'hFFFFFFFF);
      vecs[10] = mk("lbu_off3", 32'h1c000028, 1'b1, 5'd15, 1'b1, 3'b010, 32'h00000083, 32'h80000000, 5, 32'h00000080);
      vecs[11] = mk("alu_ldop", 32'h1c00002c, 1'b1, 5'd31, 1'b0, 3'b001, 32'hDEAD0081, 32'h0,        0, 32'hDEAD0081);

      resetn = 1'b0;
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = '0;
      ws_allowin = 1'b1;

      // reset state, then idle with no stimulus
      #12;
      chk("rst:allowin", ms_allowin, 1'b1);
      chk("rst:ws_valid", ms_to_ws_valid, 1'b0);
      chk("rst:ws_bus", ms_to_ws_bus, 70'd0);
      chk("rst:ds_bus", ms_to_ds_bus, 39'd0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("idle:allowin", ms_allowin, 1'b1);
      chk("idle:ws_valid", ms_to_ws_valid, 1'b0);
      chk("idle:ds_bus", ms_to_ds_bus, 39'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // lhu completes while WB is stalled: parked in DONE until WB accepts
      @(negedge clk);
      ws_allowin = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = ebus(32'h00000200, 1'b1, 5'd7, 1'b1, 3'b100, 32'h00003002);
      sb.push_back({32'h00000200, 1'b1, 5'd7, 32'h0000BEEF});
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hBEEF0000;
      #1;
      chk("done:ok_valid", ms_to_ws_valid, 1'b1);
      chk("done:ok_allowin", ms_allowin, 1'b0);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h12345678;
      #1;
      chk("done:held_valid", ms_to_ws_valid, 1'b1);
      chk("done:held_result", ms_to_ws_bus[31:0], 32'h0000BEEF);
      chk("done:held_allowin", ms_allowin, 1'b0);
      chk("done:ld_pending", ms_to_ds_bus[38], !FWD);
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h0000FFFF;
      #1;
      chk("done:spur_result", ms_to_ws_bus[31:0], 32'h0000BEEF);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      ws_allowin = 1'b1;
      #1;
      chk("done:handoff_valid", ms_to_ws_valid, 1'b1);
      chk("done:handoff_allowin", ms_allowin, 1'b1);
      sb_cmp("done");
      @(negedge clk);
      #1 chk("done:bubble", ms_to_ws_valid, 1'b0);

      // spurious data_ok in IDLE, then a normal lw
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hDEADBEEF;
      #1 chk("spur:ws_valid", ms_to_ws_valid, 1'b0);
      @(negedge clk);
      #1 chk("spur:ws_valid2", ms_to_ws_valid, 1'b0);
      data_sram_data_ok = 1'b0;
      run_vec(mk("spur_lw", 32'h1c000300, 1'b1, 5'd3, 1'b1, 3'b000, 32'h00004000, 32'hCAFEBABE, 2, 32'hCAFEBABE));

      // back-to-back: ALU, ALU, load with no gaps
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = ebus(32'h00000100, 1'b1, 5'd3, 1'b0, 3'b000, 32'hAAAA0001);
      sb.push_back({32'h00000100, 1'b1, 5'd3, 32'hAAAA0001});
      @(negedge clk);
      es_to_ms_bus = ebus(32'h00000104, 1'b1, 5'd4, 1'b0, 3'b000, 32'h00000055);
      #1;
      chk("b2b:a_valid", ms_to_ws_valid, 1'b1);
      chk("b2b:a_allowin", ms_allowin, 1'b1);
      sb_cmp("b2b_a");
      sb.push_back({32'h00000104, 1'b1, 5'd4, 32'h00000055});
      @(negedge clk);
      es_to_ms_bus = ebus(32'h00000108, 1'b1, 5'd6, 1'b1, 3'b000, 32'h00002000);
      #1;
      chk("b2b:b_valid", ms_to_ws_valid, 1'b1);
      sb_cmp("b2b_b");
      sb.push_back({32'h00000108, 1'b1, 5'd6, 32'h0BADF00D});
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      #1;
      chk("b2b:c_wait_valid", ms_to_ws_valid, 1'b0);
      chk("b2b:c_wait_pending", ms_to_ds_bus[38], 1'b1);
      chk("b2b:c_wait_allowin", ms_allowin, 1'b0);
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h0BADF00D;
      #1;
      chk("b2b:c_valid", ms_to_ws_valid, 1'b1);
      chk("b2b:c_pending", ms_to_ds_bus[38], !FWD);
      sb_cmp("b2b_c");
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1 chk("b2b:bubble", ms_to_ws_valid, 1'b0);

      // reset asserted while a load waits, then a stale data_ok
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = ebus(32'h00000400, 1'b1, 5'd9, 1'b1, 3'b000, 32'h00005000);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      #1 chk("rstw:pending", ms_to_ds_bus[38], 1'b1);
      #2 resetn = 1'b0;
      #1;
      chk("rstw:allowin", ms_allowin, 1'b1);
      chk("rstw:ws_valid", ms_to_ws_valid, 1'b0);
      chk("rstw:ws_bus", ms_to_ws_bus, 70'd0);
      chk("rstw:ds_bus", ms_to_ds_bus, 39'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h55AA55AA;
      #1;
      chk("rstw:stale_valid", ms_to_ws_valid, 1'b0);
      chk("rstw:stale_ds", ms_to_ds_bus, 39'd0);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1 chk("rstw:after_valid", ms_to_ws_valid, 1'b0);

      chk("sb:drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
